// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: canonical NOP encoding and the program ROM state type.
package rv32_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } prog_rom_state_e;

endpackage

// File: rtl/prog_rom_if.sv
// Load-stream and fetch-port bundle for prog_rom.
// Optional misalign flag appears when PROG_ROM_ALIGN_CHK_EN is defined.
interface prog_rom_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 7
);

  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [CNT_W-1:0]  load_count;
  logic              fetch_req;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              data_valid;

`ifdef PROG_ROM_ALIGN_CHK_EN
  logic              misalign;

  modport master (
    output load_start, load_valid, load_byte, load_last, fetch_req, addr,
    input  load_ready, load_done, load_count, data, data_valid, misalign
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_last, fetch_req, addr,
    output load_ready, load_done, load_count, data, data_valid, misalign
  );
`else
  modport master (
    output load_start, load_valid, load_byte, load_last, fetch_req, addr,
    input  load_ready, load_done, load_count, data, data_valid
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_last, fetch_req, addr,
    output load_ready, load_done, load_count, data, data_valid
  );
`endif

endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: little-endian word assembly, write pointer and
// RUN/LOAD/DONE sequencing. Produces a same-edge write strobe for the ROM array.
module prog_loader
  import rv32_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [7:0]                 load_byte,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       load_done,
  output logic [$clog2(DEPTH):0]     load_count,
  output logic                       busy,
  output logic                       we,
  output logic [$clog2(DEPTH)-1:0]   waddr,
  output logic [31:0]                wdata
);

  localparam int IDX_W = $clog2(DEPTH);

  prog_rom_state_e    state_r, state_next;
  logic [IDX_W-1:0]   ptr_r, ptr_next;
  logic [1:0]         idx_r, idx_next;
  logic [23:0]        word_r, word_next;
  logic [IDX_W:0]     cnt_r, cnt_next;
  logic               ready_r, done_r;
  logic [31:0]        asm_word;

  // Merge the incoming byte with the bytes already collected; upper bytes stay zero.
  always_comb begin
    asm_word = 32'h0000_0000;
    case (idx_r)
      2'd0:    asm_word = {24'h00_0000, load_byte};
      2'd1:    asm_word = {16'h0000, load_byte, word_r[7:0]};
      2'd2:    asm_word = {8'h00, load_byte, word_r[15:0]};
      2'd3:    asm_word = {load_byte, word_r[23:0]};
      default: asm_word = 32'h0000_0000;
    endcase
  end

  // Next-state, pointer and write-strobe logic.
  always_comb begin
    state_next = state_r;
    ptr_next   = ptr_r;
    idx_next   = idx_r;
    word_next  = word_r;
    cnt_next   = cnt_r;
    we         = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (load_start) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          idx_next   = 2'd0;
          word_next  = 24'h00_0000;
          cnt_next   = '0;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          ptr_next  = '0;
          idx_next  = 2'd0;
          word_next = 24'h00_0000;
          cnt_next  = '0;
        end else if (load_valid && !reset) begin
          // A word is committed when it fills up or the stream ends; reset abandons it.
          if (idx_r == 2'd3 || load_last) begin
            we        = 1'b1;
            ptr_next  = ptr_r + IDX_W'(1);
            cnt_next  = cnt_r + (IDX_W + 1)'(1);
            idx_next  = 2'd0;
            word_next = 24'h00_0000;
            if (load_last || ptr_r == IDX_W'(DEPTH - 1)) begin
              state_next = ST_DONE;
            end else begin
              state_next = ST_LOAD;
            end
          end else begin
            idx_next  = idx_r + 2'd1;
            word_next = asm_word[23:0];
          end
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_DONE: state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // State, pointer and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
      ptr_r   <= '0;
      idx_r   <= 2'd0;
      word_r  <= 24'h00_0000;
      cnt_r   <= '0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      ptr_r   <= ptr_next;
      idx_r   <= idx_next;
      word_r  <= word_next;
      cnt_r   <= cnt_next;
      ready_r <= (state_next == ST_LOAD);
      done_r  <= (state_next == ST_DONE);
    end
  end

  assign load_ready = ready_r;
  assign load_done  = done_r;
  assign load_count = cnt_r;
  assign busy       = (state_r != ST_RUN);
  assign waddr      = ptr_r;
  assign wdata      = asm_word;

endmodule

// File: rtl/prog_rom.sv
// Loadable instruction ROM with a latency-1 fetch port; out-of-range fetches return NOP_WORD.
// Define PROG_ROM_ALIGN_CHK_EN to add the misalign flag and NOP substitution for unaligned fetches.
module prog_rom #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = rv32_pkg::NOP_WORD
) (
  input  logic      clk,
  input  logic      reset,
  prog_rom_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH] = '{default: NOP_WORD};
  logic             busy;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [31:0]      wdata;
  logic             fetch_acc;
  logic             in_range;
  logic             bad_align;
  logic [31:0]      rd_word;
  logic [31:0]      data_r;
  logic             data_valid_r;
  logic             misalign_r;

  prog_loader #(.DEPTH(DEPTH)) u_loader (
    .clk        (clk),
    .reset      (reset),
    .load_start (bus.load_start),
    .load_valid (bus.load_valid),
    .load_byte  (bus.load_byte),
    .load_last  (bus.load_last),
    .load_ready (bus.load_ready),
    .load_done  (bus.load_done),
    .load_count (bus.load_count),
    .busy       (busy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  // Program array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Fetch decode: a load request in the same cycle takes priority over the fetch.
  always_comb begin
    fetch_acc = bus.fetch_req && !busy && !bus.load_start;
    in_range  = (bus.addr[ADDR_W-1:IDX_W+2] == '0);
`ifdef PROG_ROM_ALIGN_CHK_EN
    bad_align = (bus.addr[1:0] != 2'b00);
`else
    bad_align = 1'b0;
`endif
    if (in_range && !bad_align) begin
      rd_word = mem[bus.addr[IDX_W+1:2]];
    end else begin
      rd_word = NOP_WORD;
    end
  end

  // Registered fetch response; data holds when no fetch is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r       <= 32'h0000_0000;
      data_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      data_valid_r <= fetch_acc;
      misalign_r   <= fetch_acc && bad_align;
      if (fetch_acc) begin
        data_r <= rd_word;
      end
    end
  end

  assign bus.data       = data_r;
  assign bus.data_valid = data_valid_r;
`ifdef PROG_ROM_ALIGN_CHK_EN
  assign bus.misalign   = misalign_r;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{bus.addr[1:0], misalign_r};
`endif

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom (DEPTH=16): a reference memory model feeds an
// expected-fetch queue that is popped when the DUT answers.
module tb_prog_rom;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  prog_rom_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  prog_rom #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  int          m_widx;
  int          m_bidx;
  logic [31:0] m_word;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    if (a[31:2] >= 30'(DEPTH)) return NOP;
`ifdef PROG_ROM_ALIGN_CHK_EN
    if (a[1:0] != 2'b00) return NOP;
`endif
    return model[a[5:2]];
  endfunction

  task automatic fetch(input logic [31:0] a, input string tag);
    bus.fetch_req = 1'b1;
    bus.addr      = a;
    exp_q.push_back(exp_fetch(a));
    step();
    bus.fetch_req = 1'b0;
    chk({tag, "_valid"}, 32'(bus.data_valid), 32'd1);
    chk({tag, "_data"}, bus.data, exp_q.pop_front());
`ifdef PROG_ROM_ALIGN_CHK_EN
    chk({tag, "_misalign"}, 32'(bus.misalign), 32'(a[1:0] != 2'b00));
`endif
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    m_widx = 0; m_bidx = 0; m_word = 32'd0; exp_cnt = 0;
    chk("start_cnt", 32'(bus.load_count), 32'd0);
    chk("start_ready", 32'(bus.load_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    bus.load_last  = last;
    m_word = m_word | (32'(b) << (8 * m_bidx));
    m_bidx++;
    if (m_bidx == 4 || last) begin
      model[m_widx] = m_word;
      m_widx++;
      exp_cnt = m_widx;
      m_bidx  = 0;
      m_word  = 32'd0;
    end
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, 32'(bus.load_done), 32'd1);
    chk({tag, "_cnt"}, 32'(bus.load_count), 32'(exp_cnt));
    step();
    chk({tag, "_done_drop"}, 32'(bus.load_done), 32'd0);
    chk({tag, "_ready_drop"}, 32'(bus.load_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_byte = 8'h00;
    bus.load_last  = 1'b0; bus.fetch_req  = 1'b0; bus.addr      = 32'h0;

    step(); step();
    chk("rst_data", bus.data, 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_cnt", 32'(bus.load_count), 32'd0);
    reset = 1'b0;

    fetch(32'h0, "init_f0");
    step();
    chk("idle_valid", 32'(bus.data_valid), 32'd0);
    chk("idle_hold", bus.data, NOP);

    // single full word
    start_load();
    send_byte(8'h33, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h00, 1'b1);
    expect_done("w1");
    fetch(32'h0, "w1_f0");

    // one word plus a zero-padded partial word
    start_load();
    send_byte(8'h13, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h72, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
    expect_done("w2");
    fetch(32'h0, "w2_f0");
    fetch(32'h4, "w2_f4");
    fetch(32'h8, "w2_f8");

    // restart mid-load, fetch ignored while loading
    start_load();
    bus.fetch_req = 1'b1; bus.addr = 32'h0;
    send_byte(8'h01, 1'b0);
    bus.fetch_req = 1'b0;
    chk("load_fetch_ign", 32'(bus.data_valid), 32'd0);
    send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    chk("pre_restart_cnt", 32'(bus.load_count), 32'd1);
    start_load();
    send_byte(8'h05, 1'b1);
    expect_done("rs");
    fetch(32'h0, "rs_f0");
    fetch(32'h4, "rs_f4");

    // fetch + load_start in one cycle, then reset mid-word
    bus.fetch_req = 1'b1; bus.addr = 32'h4;
    start_load();
    bus.fetch_req = 1'b0;
    chk("start_fetch_ign", 32'(bus.data_valid), 32'd0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_bidx = 0; m_word = 32'd0;
    chk("mid_rst_cnt", 32'(bus.load_count), 32'd0);
    chk("mid_rst_ready", 32'(bus.load_ready), 32'd0);
    chk("mid_rst_data", bus.data, 32'd0);
    fetch(32'h0, "mid_rst_f0");

    // stream past capacity without load_last
    start_load();
    for (int i = 0; i < 70; i++) begin
      chk("ovf_ready", 32'(bus.load_ready), (i < 64) ? 32'd1 : 32'd0);
      if (i < 64) begin
        send_byte(8'(i + 128), 1'b0);
      end else begin
        bus.load_valid = 1'b1; bus.load_byte = 8'hFF;
        step();
        bus.load_valid = 1'b0;
      end
      if (i == 63) begin
        chk("ovf_done", 32'(bus.load_done), 32'd1);
        chk("ovf_cnt_at_done", 32'(bus.load_count), 32'd16);
      end
    end
    chk("ovf_cnt", 32'(bus.load_count), 32'd16);
    chk("ovf_ready_end", 32'(bus.load_ready), 32'd0);

    fetch(32'h0,   "ovf_f0");
    fetch(32'h3C,  "ovf_f3c");
    fetch(32'h40,  "oor_f40");
    fetch(32'h100, "oor_f100");
    fetch(32'h6,   "mis_f6");
    fetch(32'h4,   "al_f4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
